// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for one elastic pipeline stage: upstream beat, downstream beat,
// flush and the back-pressure counter controls.
interface pipe_skid_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_clr;

  // The stage itself.
  modport slave (
    input  flush, in_valid, in_data, out_ready, stall_clr,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  // The surrounding pipeline (upstream producer + downstream consumer).
  modport master (
    output flush, in_valid, in_data, out_ready, stall_clr,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with one skid entry, NOP-loading flush/bubbles and a
// saturating back-pressure counter.
module pipe_skid_stage #(
  parameter int               WIDTH           = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE       = {WIDTH{1'b0}},
  parameter bit               CLEAR_ON_BUBBLE = 1'b1,
  parameter int               CNT_W           = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_skid_stage_if.slave  bus
);

  // Handshake: a beat moves on a side in any cycle where its valid and ready are
  // both 1 at the rising edge. in_ready depends only on the skid register, so
  // there is no combinational path from out_ready back to in_ready; a producer
  // may raise in_valid at any time but must hold in_data while stalled.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             main_v;
  logic [WIDTH-1:0] main_d;
  logic             skid_v;
  logic [WIDTH-1:0] skid_d;
  logic [CNT_W-1:0] stall_q;

  logic acc;
  logic drn;
  logic main_load;

  assign acc       = bus.in_valid & ~skid_v;
  assign drn       = main_v & bus.out_ready;
  assign main_load = ~main_v | drn;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      main_v <= 1'b0;
      main_d <= NOP_VALUE;
      skid_v <= 1'b0;
      skid_d <= NOP_VALUE;
    end else if (main_load) begin
      if (skid_v) begin
        // Skid is older than anything upstream, so it refills main first.
        main_v <= 1'b1;
        main_d <= skid_d;
        skid_v <= 1'b0;
        if (CLEAR_ON_BUBBLE) skid_d <= NOP_VALUE;
      end else if (acc) begin
        main_v <= 1'b1;
        main_d <= bus.in_data;
      end else begin
        main_v <= 1'b0;
        if (CLEAR_ON_BUBBLE) main_d <= NOP_VALUE;
      end
    end else if (acc) begin
      skid_v <= 1'b1;
      skid_d <= bus.in_data;
    end
  end

  // Counts cycles where a valid beat is held back; flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst || bus.stall_clr) begin
      stall_q <= '0;
    end else if (main_v && !bus.out_ready && stall_q != CNT_MAX) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = ~skid_v;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_d;
  assign bus.occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign bus.stall_cnt = stall_q;

endmodule
